// File: rtl/tone_player.sv
// tone_player: square-wave note/rest player taking (half-period, duration) commands over valid/ready.
// Optional TONE_PLAYER_QUEUE_EN adds a one-entry pending slot so back-to-back notes play gaplessly.
module tone_player #(
  parameter int DIV_W    = 16,
  parameter int DUR_W    = 16,
  parameter int TICK_DIV = 100000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [DIV_W-1:0] cmd_half_period,
  input  logic [DUR_W-1:0] cmd_duration,
  output logic             speaker,
  output logic             busy,
  output logic             done
);
  localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

  typedef enum logic {IDLE, PLAY} state_t;
  state_t state;

  logic [DIV_W-1:0] half_period;
  logic [DIV_W-1:0] phase;
  logic [DUR_W-1:0] duration;
  logic [DUR_W-1:0] ticks;
  logic [PRE_W-1:0] prescale;
  logic [DUR_W-1:0] cmd_dur_eff;
  logic             accept;
  logic             note_end;

`ifdef TONE_PLAYER_QUEUE_EN
  logic             pend_vld;
  logic [DIV_W-1:0] pend_hp;
  logic [DUR_W-1:0] pend_dur;
`endif

  assign accept      = cmd_valid && cmd_ready;
  assign cmd_dur_eff = (cmd_duration == '0) ? DUR_W'(1) : cmd_duration;
  assign note_end    = (state == PLAY) && (prescale == PRE_LAST) &&
                       (ticks == duration - DUR_W'(1));
  // decoded purely from registered counters, so done never depends on inputs
  assign done        = note_end;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      speaker     <= 1'b0;
      busy        <= 1'b0;
      cmd_ready   <= 1'b1;
      half_period <= '0;
      phase       <= '0;
      duration    <= '0;
      ticks       <= '0;
      prescale    <= '0;
`ifdef TONE_PLAYER_QUEUE_EN
      pend_vld    <= 1'b0;
      pend_hp     <= '0;
      pend_dur    <= '0;
`endif
    end else if (state == IDLE) begin
      if (accept) begin
        state       <= PLAY;
        busy        <= 1'b1;
        half_period <= cmd_half_period;
        duration    <= cmd_dur_eff;
        phase       <= '0;
        ticks       <= '0;
        prescale    <= '0;
`ifndef TONE_PLAYER_QUEUE_EN
        cmd_ready   <= 1'b0;
`endif
      end
    end else if (note_end) begin
      phase    <= '0;
      ticks    <= '0;
      prescale <= '0;
`ifdef TONE_PLAYER_QUEUE_EN
      // a follow-on tone inherits the current speaker level; a rest forces it low
      if (pend_vld) begin
        half_period <= pend_hp;
        duration    <= pend_dur;
        pend_vld    <= 1'b0;
        cmd_ready   <= 1'b1;
        if (pend_hp == '0) speaker <= 1'b0;
      end else if (accept) begin
        half_period <= cmd_half_period;
        duration    <= cmd_dur_eff;
        if (cmd_half_period == '0) speaker <= 1'b0;
      end else begin
        state   <= IDLE;
        busy    <= 1'b0;
        speaker <= 1'b0;
      end
`else
      state     <= IDLE;
      busy      <= 1'b0;
      speaker   <= 1'b0;
      cmd_ready <= 1'b1;
`endif
    end else begin
      if (half_period != '0) begin
        if (phase == half_period - DIV_W'(1)) begin
          phase   <= '0;
          speaker <= ~speaker;
        end else begin
          phase <= phase + DIV_W'(1);
        end
      end
      if (prescale == PRE_LAST) begin
        prescale <= '0;
        ticks    <= ticks + DUR_W'(1);
      end else begin
        prescale <= prescale + PRE_W'(1);
      end
`ifdef TONE_PLAYER_QUEUE_EN
      if (accept) begin
        pend_vld  <= 1'b1;
        pend_hp   <= cmd_half_period;
        pend_dur  <= cmd_dur_eff;
        cmd_ready <= 1'b0;
      end
`endif
    end
  end
endmodule

// File: tb/tb_tone_player.sv
// tb_tone_player: directed + random note commands, per-cycle outputs checked against a note-level model.
module tb_tone_player;
  localparam int TD = 4;
`ifdef TONE_PLAYER_QUEUE_EN
  localparam bit QEN = 1'b1;
`else
  localparam bit QEN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_half_period;
  logic [7:0] cmd_duration;
  logic       speaker;
  logic       busy;
  logic       done;

  tone_player #(.DIV_W(8), .DUR_W(8), .TICK_DIV(TD)) dut (
    .clk(clk),
    .rst(rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_half_period(cmd_half_period),
    .cmd_duration(cmd_duration),
    .speaker(speaker),
    .busy(busy),
    .done(done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic spk;
    logic bsy;
    logic dn;
    logic rdy;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  bit   accepted;

  // note-level model: one active note (start cycle, half period, length, starting level) plus a pending slot
  bit m_act;
  int m_start;
  int m_hp;
  int m_len;
  bit m_l0;
  bit m_pv;
  int m_php;
  int m_pdur;

  function automatic bit level_at(int c);
    if (!m_act || m_hp == 0) return 1'b0;
    return m_l0 ^ ((((c - m_start) / m_hp) % 2) == 1);
  endfunction

  function automatic exp_t predict(int c);
    exp_t e;
    e.spk = level_at(c);
    e.bsy = m_act;
    e.dn  = m_act && ((c - m_start) == (m_len - 1));
    e.rdy = m_act ? (QEN && !m_pv) : 1'b1;
    return e;
  endfunction

  task automatic start_note(int c, int hp, int du, bit l0);
    m_act   = 1'b1;
    m_start = c + 1;
    m_hp    = hp;
    m_len   = ((du == 0) ? 1 : du) * TD;
    m_l0    = (hp == 0) ? 1'b0 : l0;
  endtask

  task automatic step(bit v, int hp, int du, bit r);
    exp_t e;
    e = predict(cyc);
    sb.push_back(e);
    rst             = r;
    cmd_valid       = v;
    cmd_half_period = 8'(hp);
    cmd_duration    = 8'(du);
    accepted        = v && e.rdy && !r;
    if (r) begin
      m_act = 1'b0;
      m_pv  = 1'b0;
    end else if (!m_act) begin
      if (accepted) start_note(cyc, hp, du, 1'b0);
    end else if (e.dn) begin
      if (m_pv) begin
        start_note(cyc, m_php, m_pdur, level_at(cyc));
        m_pv = 1'b0;
      end else if (accepted) begin
        start_note(cyc, hp, du, level_at(cyc));
      end else begin
        m_act = 1'b0;
      end
    end else if (accepted) begin
      m_pv   = 1'b1;
      m_php  = hp;
      m_pdur = du;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(int n);
    for (int k = 0; k < n; k++) step(1'b0, 0, 0, 1'b0);
  endtask

  task automatic send(int hp, int du);
    for (int k = 0; k < 200; k++) begin
      step(1'b1, hp, du, 1'b0);
      if (accepted) return;
    end
    tests++;
    fails++;
    $display("FAIL send_timeout: hp=%0d dur=%0d got no accept, required accept within 200 cycles", hp, du);
  endtask

  task automatic chk(string name, logic act, logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %b, expected %b", name, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() != 0) begin
      mon_e = sb.pop_front();
      chk("speaker", speaker, mon_e.spk);
      chk("busy", busy, mon_e.bsy);
      chk("done", done, mon_e.dn);
      chk("cmd_ready", cmd_ready, mon_e.rdy);
    end
  end

  initial begin
    int hp;
    int du;
    int gap;
    rst             = 1'b1;
    cmd_valid       = 1'b0;
    cmd_half_period = '0;
    cmd_duration    = '0;
    m_act = 1'b0; m_start = 0; m_hp = 0; m_len = 0; m_l0 = 1'b0;
    m_pv  = 1'b0; m_php = 0; m_pdur = 0;
    repeat (3) @(posedge clk);
    #1;
    idle(2);

    send(8, 2); idle(12);
    send(1, 1); idle(8);
    send(0, 3); idle(16);
    send(5, 0); idle(8);
    send(3, 4); idle(6);
    step(1'b0, 0, 0, 1'b1);
    idle(2);
    send(3, 2); idle(12);
    send(4, 2); send(6, 2); idle(24);
    send(2, 1); send(0, 1); send(3, 2); idle(20);

    for (int i = 0; i < 80; i++) begin
      hp  = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 12));
      du  = int'($urandom_range(0, 3));
      gap = int'($urandom_range(0, 6));
      send(hp, du);
      if ($urandom_range(0, 29) == 0) step(1'b0, 0, 0, 1'b1);
      for (int g = 0; g < gap; g++) step(1'b0, 0, 0, 1'b0);
    end
    idle(30);

    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/tone_player.md
# tone_player

Parametrised square-wave note player for the music box speaker output. Accepts note commands (half-period in clock cycles plus duration in ticks) over a valid/ready handshake. It drives `speaker` with a 50 % duty square wave for exactly the commanded duration, then signals completion. It generalises the fixed divide-by-16 tone generator to any pitch, adds rests and timed notes, and sits between the song sequencer and the speaker pin.

## Interface
- `DIV_W`, 16: width of half-period field and phase counter.
- `DUR_W`, 16: width of duration field and duration counter.
- `TICK_DIV`, 100000: clocks per duration tick, ≥1.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  reset; the only reset is `rst`, synchronous and active-high.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  block can accept a command this cycle.
- `cmd_half_period`  in  DIV_W  clocks per speaker half-cycle; 0 = rest (silence).
- `cmd_duration`  in  DUR_W  note length in ticks; 0 treated as 1.
- `speaker`  out  1  square-wave output.
- `busy`  out  1  high while a note/rest is playing.
- `done`  out  1  one-cycle pulse on the last cycle of each note/rest.

## Operation
- States: IDLE, PLAY.
- Reset: state IDLE; `speaker`=0, `busy`=0, `done`=0, `cmd_ready`=1; all counters 0; pending slot empty.
- Accept = `cmd_valid && cmd_ready`. On accept in IDLE: latch half-period and duration (0→1), clear phase counter, prescaler and tick counter, go to PLAY.
- PLAY, tone (hp≠0): phase counter counts 0..hp-1 and wraps. On the cycle it equals hp-1, `speaker` toggles. hp=1 gives a toggle every cycle.
- PLAY, rest (hp=0): `speaker` held 0; phase counter held 0.
- Prescaler counts 0..TICK_DIV-1. At wrap, the tick counter increments. A note ends on the cycle the prescaler wraps with tick counter = duration-1, so the note lasts exactly duration×TICK_DIV cycles. `done` pulses on that cycle.
- End of note with nothing pending: next cycle IDLE, `speaker`=0, `busy`=0.
- `cmd_valid` is ignored when `cmd_ready`=0. The command fields must stay stable while `cmd_valid`=1 and `cmd_ready`=0.
- Arithmetic: all counters unsigned, compared with equality only. Phase counter DIV_W bits; tick counter DUR_W bits; prescaler ceil(log2(TICK_DIV)) bits, minimum 1.
- `rst` asserted mid-note: the next cycle matches reset state exactly; the pending slot is discarded.

## Timing
- Accept at cycle T: `busy`=1 from T+1. First `speaker` edge visible at T+1+hp.
- `done` is high during cycle T+duration×TICK_DIV. `busy` falls at T+duration×TICK_DIV+1 unless a pending note loads.
- `cmd_ready` is a registered function of state and pending occupancy. There is no combinational path from `cmd_valid` to `cmd_ready`.

## Configuration
- `TONE_PLAYER_QUEUE_EN` defined: adds a one-entry pending register.
  - `cmd_ready` = pending slot empty, including during PLAY.
  - A command accepted during PLAY waits in the slot.
  - At note end, the pending note loads on the cycle after `done`, so playback is gapless: `busy` stays 1 and the counters clear.
  - `speaker` keeps its current level across a tone→tone load. It is forced to 0 when the new note is a rest.
  - When accept and note end coincide with an empty slot, the new command loads directly on the next cycle, also gapless.
- Not defined: no pending register. `cmd_ready`=1 only in IDLE, and there is at least one IDLE cycle between notes.

## Test plan
- Reset release, then hp=8, duration=2, TICK_DIV=16 → `speaker` toggles every 8 cycles (first edge at T+9); 4 toggles total; `done` at T+32; `speaker`=0 and `busy`=0 at T+33.
- hp=1, duration=1, TICK_DIV=4 → `speaker` toggles on each of 4 cycles; single `done` pulse; back to IDLE.
- Rest: hp=0, duration=3, TICK_DIV=4 → `speaker` stays 0 for 12 cycles; `busy`=1 throughout; `done` at T+12.
- duration=0, hp=5, TICK_DIV=10 → behaves as duration=1: `done` at T+10, 2 toggles.
- `rst` pulsed mid-note (hp=3 at cycle 7) → next cycle `speaker`=0, `busy`=0, `cmd_ready`=1; a later command plays from a cleared phase.
- With `TONE_PLAYER_QUEUE_EN`: hp=4/dur=1 then hp=6/dur=1 queued during the first note (TICK_DIV=8) → second note starts at T+9 with no IDLE cycle, `speaker` level unchanged at the boundary, `done` at T+8 and T+16. Without the macro: `cmd_ready`=0 during PLAY and the second command is accepted only at T+9.
